// File: rtl/kbd_pwm_ctrl_if.sv
// Keyboard-side bundle for kbd_pwm_ctrl: released-key strobe in, decode status and duty out.
// The master modport is the keyboard receiver / display side; the slave modport is the controller.
interface kbd_pwm_ctrl_if;
    logic [7:0] scancode;
    logic       flag;
    logic [7:0] duty;
    logic       key_ok;
    logic       key_bad;

    modport master (output scancode, output flag, input duty, input key_ok, input key_bad);
    modport slave  (input scancode, input flag, output duty, output key_ok, output key_bad);
endinterface

// File: rtl/kbd_pwm_ctrl.sv
// Decodes released Set-2 scancodes into duty commands and drives an 8-bit PWM whose
// duty is only reloaded at period boundaries, so the output never glitches mid-period.
module kbd_pwm_ctrl #(
    parameter int unsigned PRESCALE   = 16,
    parameter int unsigned STEP       = 8,
    parameter logic [7:0]  DUTY_RESET = 8'd128
) (
    input  logic          clk,
    input  logic          reset,
    kbd_pwm_ctrl_if.slave kbd,
    output logic          pwm_out
);

    typedef enum logic [7:0] {
        SC_W = 8'h1D,
        SC_S = 8'h1B,
        SC_R = 8'h2D,
        SC_F = 8'h2B,
        SC_0 = 8'h45,
        SC_1 = 8'h16,
        SC_2 = 8'h1E,
        SC_3 = 8'h26,
        SC_4 = 8'h25,
        SC_5 = 8'h2E,
        SC_6 = 8'h36,
        SC_7 = 8'h3D,
        SC_8 = 8'h3E,
        SC_9 = 8'h46
    } scancode_e;

    logic [7:0]  duty_target_q, duty_target_d;
    logic [7:0]  duty_active_q, duty_active_d;
    logic [15:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic        pwm_out_q, pwm_out_d;
    logic        key_ok_q, key_ok_d;
    logic        key_bad_q, key_bad_d;

    logic        tick;
    logic [8:0]  inc_sum;

    always_comb begin
        duty_target_d = duty_target_q;
        key_ok_d      = 1'b0;
        key_bad_d     = 1'b0;
        inc_sum       = {1'b0, duty_target_q} + 9'(STEP);
        if (kbd.flag) begin
            key_ok_d = 1'b1;
            case (kbd.scancode)
                SC_W: duty_target_d = inc_sum[8] ? 8'hFF : inc_sum[7:0];
                SC_S: duty_target_d = (duty_target_q < 8'(STEP)) ? '0 : duty_target_q - 8'(STEP);
                SC_R: duty_target_d = DUTY_RESET;
                SC_F: duty_target_d = '1;
                SC_0: duty_target_d = 8'd0;
                SC_1: duty_target_d = 8'd28;
                SC_2: duty_target_d = 8'd56;
                SC_3: duty_target_d = 8'd84;
                SC_4: duty_target_d = 8'd112;
                SC_5: duty_target_d = 8'd140;
                SC_6: duty_target_d = 8'd168;
                SC_7: duty_target_d = 8'd196;
                SC_8: duty_target_d = 8'd224;
                SC_9: duty_target_d = 8'd252;
                default: begin
                    key_ok_d  = 1'b0;
                    key_bad_d = 1'b1;
                end
            endcase
        end
    end

    // With PRESCALE=1 the compare is against 0 and pre_cnt never leaves 0, so tick stays high.
    always_comb begin
        tick          = (pre_cnt_q == 16'(PRESCALE - 1));
        pre_cnt_d     = tick ? '0 : pre_cnt_q + 16'd1;
        pwm_cnt_d     = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        duty_active_d = (tick && (pwm_cnt_q == 8'hFF)) ? duty_target_q : duty_active_q;
        pwm_out_d     = (pwm_cnt_q < duty_active_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_target_q <= DUTY_RESET;
            duty_active_q <= DUTY_RESET;
            pre_cnt_q     <= '0;
            pwm_cnt_q     <= '0;
            pwm_out_q     <= 1'b0;
            key_ok_q      <= 1'b0;
            key_bad_q     <= 1'b0;
        end else begin
            duty_target_q <= duty_target_d;
            duty_active_q <= duty_active_d;
            pre_cnt_q     <= pre_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            pwm_out_q     <= pwm_out_d;
            key_ok_q      <= key_ok_d;
            key_bad_q     <= key_bad_d;
        end
    end

    assign kbd.duty    = duty_target_q;
    assign kbd.key_ok  = key_ok_q;
    assign kbd.key_bad = key_bad_q;
    assign pwm_out     = pwm_out_q;

endmodule

// File: tb/tb_kbd_pwm_ctrl.sv
// Scoreboard bench for kbd_pwm_ctrl: a cycle-indexed reference model predicts key pulses,
// displayed duty and pwm_out; a negedge monitor pops and compares.
module tb_kbd_pwm_ctrl;
    localparam int unsigned P      = 2;
    localparam int unsigned STEP   = 8;
    localparam logic [7:0]  DR     = 8'd128;
    localparam int unsigned PERIOD = 256 * P;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pwm_out;

    kbd_pwm_ctrl_if kif ();

    kbd_pwm_ctrl #(.PRESCALE(P), .STEP(STEP), .DUTY_RESET(DR)) dut (
        .clk    (clk),
        .reset  (reset),
        .kbd    (kif.slave),
        .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;   // 1 = recognised, 2 = unrecognised
        logic [7:0] duty;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    logic [7:0]  m_target = DR;
    logic [7:0]  m_active = DR;
    logic        exp_pwm = 1'b0;
    bit          model_live = 1'b0;

    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] key_pool [14] = '{8'h1D, 8'h1B, 8'h2D, 8'h2B, 8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                                  8'h36, 8'h3D, 8'h3E, 8'h46};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    function automatic void apply_key(input logic [7:0] code, input logic [7:0] cur,
                                      output int kind, output logic [7:0] nxt);
        int v;
        nxt  = cur;
        kind = 2;
        for (int i = 0; i < 10; i++)
            if (code == digit_codes[i]) begin
                kind = 1;
                nxt  = 8'(i * 28);
            end
        if (code == 8'h1D) begin
            kind = 1;
            v    = int'(cur) + int'(STEP);
            nxt  = (v > 255) ? 8'd255 : 8'(v);
        end else if (code == 8'h1B) begin
            kind = 1;
            v    = int'(cur) - int'(STEP);
            nxt  = (v < 0) ? 8'd0 : 8'(v);
        end else if (code == 8'h2D) begin
            kind = 1;
            nxt  = DR;
        end else if (code == 8'h2B) begin
            kind = 1;
            nxt  = 8'd255;
        end
    endfunction

    // Reference model: cyc is the index of the cycle in progress since reset; pwm_cnt is cyc/P mod 256.
    initial begin
        int         k;
        logic [7:0] n;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_target   = DR;
                m_active   = DR;
                exp_pwm    = 1'b0;
                cyc        = 0;
                model_live = 1'b1;
            end else if (model_live) begin
                exp_pwm = (((cyc / P) % 256) < m_active);
                if (((cyc + 1) % PERIOD) == 0)
                    m_active = m_target;
                if (kif.flag) begin
                    apply_key(kif.scancode, m_target, k, n);
                    m_target = n;
                    sbq.push_back('{kind: k, duty: n});
                end
                cyc++;
            end
        end
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (model_live) begin
                check("duty", kif.duty, m_target);
                check("pwm_out", pwm_out, exp_pwm);
                check("pulse_excl", kif.key_ok & kif.key_bad, 0);
                if (kif.key_ok || kif.key_bad) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_pulse", kif.key_ok ? 1 : 2, 0);
                    end else begin
                        e = sbq.pop_front();
                        check("pulse_kind", kif.key_ok ? 1 : 2, e.kind);
                        check("pulse_duty", kif.duty, e.duty);
                    end
                end else if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("missing_pulse", 0, e.kind);
                end
            end
        end
    end

    task automatic press(input logic [7:0] code);
        @(negedge clk);
        kif.flag     = 1'b1;
        kif.scancode = code;
        @(negedge clk);
        kif.flag     = 1'b0;
        kif.scancode = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at a negedge where the cycle in progress has index = phase mod PERIOD.
    task automatic wait_phase(input int unsigned phase);
        int i;
        i = 0;
        @(negedge clk);
        while ((cyc % PERIOD) != phase && i < 2 * PERIOD) begin
            @(negedge clk);
            i++;
        end
        if (i >= 2 * PERIOD) check("wait_phase_timeout", 1, 0);
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clk);
            hi += int'(pwm_out);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

    initial begin
        int hi;
        kif.flag     = 1'b0;
        kif.scancode = 8'h00;
        reset        = 1'b1;
        idle(3);
        reset = 1'b0;

        count_high(PERIOD, hi);
        check("reset_period_high", hi, 256);

        for (int i = 0; i < 32; i++) begin
            press(8'h1D);
            idle(2);
        end
        check("w_saturated", kif.duty, 255);

        press(8'h45);
        press(8'h1B);
        check("zero_after_s", kif.duty, 0);
        wait_phase(0);
        count_high(PERIOD, hi);
        check("zero_period_high", hi, 0);

        press(8'h2D);
        wait_phase(PERIOD - 1);
        kif.flag     = 1'b1;
        kif.scancode = 8'h3E;
        @(negedge clk);
        kif.flag = 1'b0;
        count_high(PERIOD, hi);
        check("boundary_old_duty_high", hi, 2 * 128);
        count_high(PERIOD, hi);
        check("boundary_new_duty_high", hi, 2 * 224);

        press(8'h2D);
        press(8'h1C);
        @(negedge clk);
        kif.scancode = 8'h1D;
        idle(100);
        check("ignored_no_flag", kif.duty, 128);

        @(negedge clk);
        kif.flag     = 1'b1;
        kif.scancode = 8'h1D;
        @(negedge clk);
        kif.scancode = 8'h1D;
        @(negedge clk);
        kif.scancode = 8'h1B;
        @(negedge clk);
        kif.scancode = 8'h1B;
        @(negedge clk);
        kif.flag = 1'b0;

        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 30) begin
                kif.flag     = 1'b1;
                kif.scancode = ($urandom_range(0, 9) < 7) ? key_pool[$urandom_range(0, 13)] : 8'($urandom);
            end else begin
                kif.flag     = 1'b0;
                kif.scancode = 8'($urandom);
            end
        end

        wait_phase(200);
        kif.flag     = 1'b1;
        kif.scancode = 8'h2B;
        reset        = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        kif.flag     = 1'b0;
        check("reset_duty", kif.duty, 128);
        check("reset_pwm", pwm_out, 0);
        check("reset_no_ok", kif.key_ok, 0);

        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            kif.flag     = ($urandom_range(0, 99) < 20);
            kif.scancode = key_pool[$urandom_range(0, 13)];
        end
        kif.flag = 1'b0;
        idle(4);
        check("queue_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
